// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int MIN_DIV   = 2;
   localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/clk_div_duty_fix.sv
// Odd-divisor duty correction: a negedge copy of clk_pos is ORed in to stretch the high phase by half a cycle.
// Only instantiated when CLK_DIV_DUTY50_EN is defined.
module clk_div_duty_fix (
   input  logic clk,
   input  logic rst,
   input  logic clk_pos,
   input  logic odd,
   output logic clk_out
);

   logic clk_neg_q;
   logic clk_neg_d;

   always_comb begin
      clk_neg_d = rst ? 1'b0 : clk_pos;
   end

   always_ff @(negedge clk) begin
      clk_neg_q <= clk_neg_d;
   end

   assign clk_out = odd ? (clk_pos | clk_neg_q) : clk_pos;

endmodule

// File: rtl/clk_div_n.sv
// Runtime-programmable integer clock divider with per-period tick; divisor and enable changes land on period boundaries.
// Optional 50% duty for odd divisors via macro CLK_DIV_DUTY50_EN.
module clk_div_n
   import clk_div_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int DEFAULT_DIV = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] div_val,
   output logic             clk_out,
   output logic             tick,
   output logic             busy,
   output logic             err,
   output logic [CNT_W-1:0] cur_div
);

   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] MIN_W   = CNT_W'(MIN_DIV);
   localparam logic [CNT_W-1:0] DEF_W   = CNT_W'(DEFAULT_DIV);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cur_div_q, cur_div_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic             clk_pos_q, clk_pos_d;
   logic             tick_q, tick_d;
   logic             err_q, err_d;
   logic             wrap;
   logic             div_ok;

   always_comb begin
      wrap       = (state_q == RUN) && (cnt_q == cur_div_q - ONE);
      div_ok     = (div_val >= MIN_W);
      state_d    = state_q;
      cnt_d      = cnt_q;
      cur_div_d  = cur_div_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      err_d      = load && !div_ok;

      // The old pending value is applied first so a load on a wrap edge waits for the next wrap.
      if (((state_q == IDLE) || wrap) && pend_vld_q) begin
         cur_div_d  = pend_q;
         pend_vld_d = 1'b0;
      end
      if (load && div_ok) begin
         pend_d     = div_val;
         pend_vld_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (en) state_d = RUN;
         end
         RUN: begin
            if (wrap) begin
               cnt_d = '0;
               if (!en) state_d = IDLE;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Outputs are registered from the next-state view so they line up with cnt_q.
      clk_pos_d = (state_d == RUN) && (cnt_d < (cur_div_d >> 1));
      tick_d    = (state_d == RUN) && (cnt_d == cur_div_d - ONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         cur_div_q  <= DEF_W;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         clk_pos_q  <= 1'b0;
         tick_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cur_div_q  <= cur_div_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         clk_pos_q  <= clk_pos_d;
         tick_q     <= tick_d;
         err_q      <= err_d;
      end
   end

`ifdef CLK_DIV_DUTY50_EN
   clk_div_duty_fix u_duty_fix (
      .clk     (clk),
      .rst     (rst),
      .clk_pos (clk_pos_q),
      .odd     (cur_div_q[0]),
      .clk_out (clk_out)
   );
`else
   assign clk_out = clk_pos_q;
`endif

   assign tick    = tick_q;
   assign busy    = (state_q == RUN);
   assign err     = err_q;
   assign cur_div = cur_div_q;

endmodule

// File: tb/tb_clk_div_n.sv
// Directed bench for clk_div_n: reset, N=3 pattern, duty, divisor loads, rejected loads, enable drop, mid-period reset.
module tb_clk_div_n;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             load;
   logic [CNT_W-1:0] div_val;
   logic             clk_out;
   logic             tick;
   logic             busy;
   logic             err;
   logic [CNT_W-1:0] cur_div;

   int checks = 0;
   int errors = 0;

   clk_div_n #(.CNT_W(CNT_W), .DEFAULT_DIV(3)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .load    (load),
      .div_val (div_val),
      .clk_out (clk_out),
      .tick    (tick),
      .busy    (busy),
      .err     (err),
      .cur_div (cur_div)
   );

   always #25 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One posedge passes; outputs are then sampled just after the following negedge.
   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic chk_run(input int c, input int n);
      chk("clk_out", 32'(clk_out), 32'(c < n / 2));
      chk("tick", 32'(tick), 32'(c == n - 1));
      chk("busy", 32'(busy), 32'd1);
      chk("cur_div", 32'(cur_div), 32'(n));
   endtask

   task automatic chk_idle(input int n);
      chk("idle_clk_out", 32'(clk_out), 32'd0);
      chk("idle_tick", 32'(tick), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_cur_div", 32'(cur_div), 32'(n));
   endtask

   initial begin
      int h;
      rst = 1'b1; en = 1'b0; load = 1'b0; div_val = '0;
      cyc(); cyc();
      chk_idle(3);
      chk("reset_err", 32'(err), 32'd0);
      $display("reset done");

      rst = 1'b0; en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         cyc();
         chk_run(i % 3, 3);
      end
      $display("N=3 run pattern done");

      // Any 6 consecutive half-cycles span one full period.
      for (int p = 0; p < 20; p++) begin
         h = 0;
         for (int k = 0; k < 6; k++) begin
            @(posedge clk or negedge clk);
            #1;
            h += int'(clk_out);
         end
`ifdef CLK_DIV_DUTY50_EN
         chk("duty_high_halves", 32'(h), 32'd3);
`else
         chk("duty_high_halves", 32'(h), 32'd2);
`endif
      end
      $display("N=3 duty over 20 periods done");

      // Load on a wrap edge: applies at the following wrap.
      load = 1'b1; div_val = 8'd4;
      cyc(); load = 1'b0;
      chk_run(0, 3);
      cyc(); chk_run(1, 3);
      cyc(); chk_run(2, 3);
      cyc(); chk_run(0, 4);
      cyc(); chk_run(1, 4);
      load = 1'b1; div_val = 8'd6;
      cyc(); load = 1'b0;
      chk_run(2, 4);
      cyc(); chk_run(3, 4);
      for (int c = 0; c < 6; c++) begin
         cyc();
         chk_run(c, 6);
      end
      $display("N=4 -> N=6 switch done");

      load = 1'b1; div_val = 8'd1;
      cyc();
      chk_run(0, 6);
      chk("err_div1", 32'(err), 32'd1);
      div_val = 8'd0;
      cyc(); load = 1'b0;
      chk_run(1, 6);
      chk("err_div0", 32'(err), 32'd1);
      cyc();
      chk_run(2, 6);
      chk("err_clear", 32'(err), 32'd0);
      for (int c = 3; c < 6; c++) begin
         cyc();
         chk_run(c, 6);
      end
      cyc(); chk_run(0, 6);
      load = 1'b1; div_val = 8'd5;
      cyc(); load = 1'b0;
      chk_run(1, 6);
      chk("err_good_load", 32'(err), 32'd0);
      for (int c = 2; c < 6; c++) begin
         cyc();
         chk_run(c, 6);
      end
      cyc(); chk_run(0, 5);
      $display("rejected loads then N=5 done");

      en = 1'b0;
      cyc(); chk_run(1, 5);
      cyc(); chk_run(2, 5);
      en = 1'b1;
      cyc(); chk_run(3, 5);
      en = 1'b0;
      cyc(); chk_run(4, 5);
      cyc(); chk_idle(5);
      repeat (3) begin
         cyc();
         chk_idle(5);
      end
      en = 1'b1;
      cyc(); chk_run(0, 5);
      cyc(); chk_run(1, 5);
      $display("enable drop and restart done");

      load = 1'b1; div_val = 8'd7;
      cyc(); load = 1'b0;
      chk_run(2, 5);
      cyc(); chk_run(3, 5);
      cyc(); chk_run(4, 5);
      cyc(); chk_run(0, 7);
      cyc(); chk_run(1, 7);
      load = 1'b1; div_val = 8'd9;
      cyc(); load = 1'b0;
      chk_run(2, 7);
      rst = 1'b1;
      cyc();
      chk_idle(3);
      chk("rst_err", 32'(err), 32'd0);
      rst = 1'b0; en = 1'b0;
      cyc(); chk_idle(3);
      cyc(); chk_idle(3);
      en = 1'b1;
      cyc(); chk_run(0, 3);
      $display("mid-period reset done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clk_div_n.md
Name: clk_div_n

Overview:
- Parametrised successor to the fixed divide-by-3 block: divides `clk` by a runtime-programmable integer N ≥ 2.
- Output is glitch-free and clean, plus a once-per-period strobe.
- Divisor changes and enable/disable take effect only at period boundaries.
- Sits at the clock-generation layer, feeding downstream blocks that need a slower rate or strobe.

Parameters:
- CNT_W, 8, width of divisor and period counter (max N = 2^CNT_W − 1).
- DEFAULT_DIV, 3, divisor loaded at reset; must be ≥ 2 and < 2^CNT_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  run request
- load  in  1  one-cycle strobe; capture div_val as pending divisor
- div_val  in  CNT_W  requested divisor
- clk_out  out  1  divided clock
- tick  out  1  one-cycle pulse in the last clk cycle of each output period
- busy  out  1  high while in RUN
- err  out  1  one-cycle pulse: rejected load
- cur_div  out  CNT_W  divisor currently in effect

Behaviour:
- Interface: one clock, `clk`; reset `rst` is synchronous and active-high. All state updates on posedge `clk`, except the DUTY50_EN negedge register.
- Reset values:
  - clk_out=0, tick=0, busy=0, err=0
  - cur_div=DEFAULT_DIV, pending-valid=0, cnt=0, state=IDLE
  - Reset mid-period aborts immediately; clk_out is low in the following cycle.
- States:
  - IDLE: clk_out=0, cnt held at 0.
  - IDLE→RUN: on the edge where en=1.
  - RUN→IDLE: at a wrap edge (cnt==cur_div−1) with en=0.
  - en dropping then re-asserting before the wrap: no effect.
- Counter in RUN:
  - cnt <= (cnt==cur_div−1) ? 0 : cnt+1.
  - On entry to RUN, cnt <= 0.
- Output shape: H = cur_div>>1.
  - clk_pos is registered, high when the next cnt < H.
  - First RUN cycle has clk_pos=1.
  - Period is exactly cur_div cycles.
  - Even N: high N/2 cycles, low N/2 cycles.
- tick: registered; high for the one cycle where cnt==cur_div−1; never asserted in IDLE.
- Divisor load:
  - load=1 with div_val ≥ 2: captures div_val into pending (overwrites any earlier pending value).
  - div_val < 2: pending unchanged; err=1 on the next cycle.
  - Pending is applied to cur_div at the next wrap edge, or on the next edge if in IDLE.
  - load coincident with a wrap edge: the new value applies at the following wrap.
- Arithmetic: unsigned CNT_W; comparisons unsigned; no overflow possible because cnt < cur_div.
- busy = (state==RUN).

Optional Feature:
- Macro: CLK_DIV_DUTY50_EN.
- Defined:
  - Adds a negedge register clk_neg <= clk_pos, reset synchronously (sampled at negedge) to 0.
  - For odd cur_div: clk_out = clk_pos | clk_neg, high (N/2) cycles exactly, i.e. 50% duty; for N=3, high 1.5 cycles, low 1.5 cycles.
  - For even cur_div: clk_out = clk_pos.
- Undefined:
  - Pure posedge design; clk_out = clk_pos.
  - Odd N gives high floor(N/2), low ceil(N/2); for N=3, high 1 cycle, low 2 cycles.
- tick and busy are identical either way.

Decomposition:
- Package clk_div_pkg:
  - state enum {IDLE, RUN}
  - constant MIN_DIV=2
  - localparam default CNT_W
- Natural sub-module: clk_div_duty_fix.
  - Contains the negedge register and the OR stage, instantiated only under CLK_DIV_DUTY50_EN.
  - Isolates the dual-edge logic for timing/CDC review.

Test Plan:
- Reset then en=1, DEFAULT_DIV=3, no macro:
  - clk_out pattern 1,0,0 repeating from the first RUN cycle.
  - tick high on every 3rd cycle; busy=1; cur_div=3.
- Same with CLK_DIV_DUTY50_EN:
  - clk_out high 75 ns, low 75 ns at 50 ns clk period.
  - Period 150 ns, checked over 20 periods.
- Running at N=4, load div_val=6 at cnt=1:
  - Current period completes as 4 cycles (2 high, 2 low).
  - Then periods are 6 cycles (3/3); cur_div changes exactly at the wrap edge.
- load div_val=1, then div_val=0:
  - err pulses one cycle after each load; cur_div and period unchanged.
  - Next load of 5 applies normally.
- en=0 asserted mid-period at N=5:
  - Period completes, busy falls at the wrap, clk_out stays 0, no further tick.
  - en=1 restarts with clk_out=1 on the first RUN cycle.
- rst=1 asserted at cnt=2 of an N=7 period:
  - Next cycle: clk_out=0, tick=0, busy=0, cur_div=3, pending cleared.
